// File: rtl/des3_key_scheduler.sv
// 3DES key scheduler: expands three 64-bit DES keys into 48 round subkeys
// over a fixed 48-cycle window and serves them in EDE encrypt/decrypt order.
module des3_key_scheduler #(
    parameter int NUM_KEYS = 3,
    parameter int ROUNDS   = 16,
    parameter int SUBKEY_W = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_load,
    input  logic [0:NUM_KEYS*64-1] keys,
    input  logic                   is_encrypt,
    input  logic [5:0]             rd_idx,
    output logic [SUBKEY_W-1:0]    subkey,
    output logic                   busy,
    output logic                   sched_done
);

    localparam int         NUM_SLOTS = NUM_KEYS * ROUNDS;
    localparam logic [5:0] LAST_CNT  = 6'(NUM_SLOTS - 1);
    localparam int         PC1_W     = 56;
    localparam int         PC2_W     = 48;

    // Tables hold zero-based FIPS-46 bit positions (bit 1 of the standard is index 0).
    localparam logic [5:0] PC1_TAB [PC1_W] = '{
        6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
        6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
        6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
        6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
        6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
        6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
        6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
    };

    localparam logic [5:0] PC2_TAB [PC2_W] = '{
        6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
        6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
        6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
        6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
        6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
        6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
        6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
        6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
    };

    function automatic logic [0:55] pc1(input logic [0:63] k);
        logic [0:55] cd;
        cd = '0;
        for (int i = 0; i < PC1_W; i++) begin
            cd[i[5:0]] = k[PC1_TAB[i[5:0]]];
        end
        return cd;
    endfunction

    function automatic logic [0:47] pc2(input logic [0:55] cd);
        logic [0:47] sk;
        sk = '0;
        for (int i = 0; i < PC2_W; i++) begin
            sk[i[5:0]] = cd[PC2_TAB[i[5:0]]];
        end
        return sk;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 start_s;
    logic                 gen_s;
    logic                 last_s;
    logic                 reload_s;
    logic                 one_shift_s;
    logic [5:0]           cnt_r;
    logic [0:NUM_KEYS*64-1] keys_r;
    logic [0:27]          c_r;
    logic [0:27]          d_r;
    logic [0:27]          c_rot_s;
    logic [0:27]          d_rot_s;
    logic [0:63]          reload_key_s;
    logic [0:55]          reload_cd_s;
    logic [0:55]          load_cd_s;
    logic [0:47]          pc2_s;
    logic [SUBKEY_W-1:0]  slots_r [NUM_SLOTS];
    logic                 busy_r;
    logic                 done_r;
    logic [1:0]           rd_k_s;
    logic [3:0]           rd_r_s;
    logic [3:0]           rd_rev_s;
    logic [5:0]           rd_slot_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; key_load is only honoured outside GEN.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (key_load) begin
                    state_nxt_s = GEN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            GEN: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = GEN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    assign gen_s    = (state_r == GEN);
    assign last_s   = gen_s && (cnt_r == LAST_CNT);
    assign reload_s = (cnt_r[3:0] == 4'd15) && (cnt_r[5:4] != 2'd2);

    // Rounds 1, 2, 9 and 16 of each key rotate by one, all others by two.
    always_comb begin
        case (cnt_r[3:0])
            4'd0, 4'd1, 4'd8, 4'd15: one_shift_s = 1'b1;
            default:                 one_shift_s = 1'b0;
        endcase
        if (one_shift_s) begin
            c_rot_s = {c_r[1:27], c_r[0]};
            d_rot_s = {d_r[1:27], d_r[0]};
        end else begin
            c_rot_s = {c_r[2:27], c_r[0:1]};
            d_rot_s = {d_r[2:27], d_r[0:1]};
        end
    end

    // Key whose PC-1 seeds C/D once the current key's 16 rounds are written.
    always_comb begin
        case (cnt_r[5:4])
            2'd0:    reload_key_s = keys_r[64:127];
            2'd1:    reload_key_s = keys_r[128:191];
            default: reload_key_s = keys_r[0:63];
        endcase
    end

    assign reload_cd_s = pc1(reload_key_s);
    assign load_cd_s   = pc1(keys[0:63]);
    assign pc2_s       = pc2({c_rot_s, d_rot_s});

    // Key latch, C/D halves, round counter, subkey file and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_r  <= '0;
            c_r     <= '0;
            d_r     <= '0;
            cnt_r   <= 6'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            slots_r <= '{default: '0};
        end else if (start_s) begin
            keys_r <= keys;
            c_r    <= load_cd_s[0:27];
            d_r    <= load_cd_s[28:55];
            cnt_r  <= 6'd0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (gen_s) begin
            slots_r[cnt_r] <= pc2_s;
            if (reload_s) begin
                c_r <= reload_cd_s[0:27];
                d_r <= reload_cd_s[28:55];
            end else begin
                c_r <= c_rot_s;
                d_r <= d_rot_s;
            end
            if (last_s) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + 6'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign rd_rev_s = 4'd15 - rd_idx[3:0];

    // Map the pipeline round index onto a slot; decrypt walks K3, K2, K1 with K3/K1 reversed.
    always_comb begin
        rd_k_s = 2'd0;
        rd_r_s = 4'd0;
        case ({is_encrypt, rd_idx[5:4]})
            3'b1_00: begin rd_k_s = 2'd0; rd_r_s = rd_idx[3:0]; end
            3'b1_01: begin rd_k_s = 2'd1; rd_r_s = rd_rev_s;    end
            3'b1_10: begin rd_k_s = 2'd2; rd_r_s = rd_idx[3:0]; end
            3'b0_00: begin rd_k_s = 2'd2; rd_r_s = rd_rev_s;    end
            3'b0_01: begin rd_k_s = 2'd1; rd_r_s = rd_idx[3:0]; end
            3'b0_10: begin rd_k_s = 2'd0; rd_r_s = rd_rev_s;    end
            default: begin rd_k_s = 2'd0; rd_r_s = 4'd0;        end
        endcase
        rd_slot_s = {rd_k_s, rd_r_s};
        if (done_r && (rd_idx <= LAST_CNT)) begin
            subkey = slots_r[rd_slot_s];
        end else begin
            subkey = '0;
        end
    end

    assign busy       = busy_r;
    assign sched_done = done_r;

endmodule

// File: tb/tb_des3_key_scheduler.sv
// Directed bench for des3_key_scheduler: schedule timing, read ordering,
// key_load while busy, and reset in the middle of generation.
module tb_des3_key_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [0:191] keys;
    logic         is_encrypt;
    logic [5:0]   rd_idx;
    logic [47:0]  subkey;
    logic         busy;
    logic         sched_done;

    int total = 0;
    int bad   = 0;
    logic [47:0] exp_q [$];
    int cur_kind [3];

    localparam int KT = 0;  // 64'h133457799BBCDFF1
    localparam int KZ = 1;  // all zeros
    localparam int KO = 2;  // all ones

    // Published round subkeys K1..K16 for key 133457799BBCDFF1.
    logic [47:0] ks_t [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    always #5 clk = ~clk;

    des3_key_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .keys       (keys),
        .is_encrypt (is_encrypt),
        .rd_idx     (rd_idx),
        .subkey     (subkey),
        .busy       (busy),
        .sched_done (sched_done)
    );

    function automatic logic [63:0] kind_key(input int kind);
        case (kind)
            KT:      return 64'h133457799BBCDFF1;
            KZ:      return 64'h0;
            default: return 64'hFFFFFFFFFFFFFFFF;
        endcase
    endfunction

    function automatic logic [47:0] kind_sub(input int kind, input int r);
        case (kind)
            KT:      return ks_t[r];
            KZ:      return 48'h0;
            default: return 48'hFFFFFFFFFFFF;
        endcase
    endfunction

    function automatic logic [47:0] model_read(input int idx, input logic enc);
        int s, j, k, r;
        if (idx > 47) return 48'h0;
        s = idx / 16;
        j = idx % 16;
        if (enc) begin
            k = s;
            r = (s == 1) ? 15 - j : j;
        end else begin
            k = 2 - s;
            r = (s == 1) ? j : 15 - j;
        end
        return kind_sub(cur_kind[k], r);
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic read_chk(input string tag, input int idx, input logic enc, input logic [47:0] want);
        @(negedge clk);
        rd_idx     = idx[5:0];
        is_encrypt = enc;
        exp_q.push_back(want);
        #2;
        chk(tag, subkey, exp_q.pop_front());
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i <= 48; i++) begin
            read_chk($sformatf("%s_enc_%0d", tag, i), i, 1'b1, model_read(i, 1'b1));
            read_chk($sformatf("%s_dec_%0d", tag, i), i, 1'b0, model_read(i, 1'b0));
        end
    endtask

    task automatic load(input int a, input int b, input int c);
        @(negedge clk);
        keys     = {kind_key(a), kind_key(b), kind_key(c)};
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Called right after load(): step n is the negedge after the n-th GEN edge.
    task automatic run_gen(input int stray_at, input int rst_at);
        for (int n = 0; n <= 48; n++) begin
            if (n > 0) @(negedge clk);
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", {47'd0, busy}, 48'd0);
                chk("rst_done", {47'd0, sched_done}, 48'd0);
                chk("rst_subkey", subkey, 48'd0);
                return;
            end
            if (n == stray_at) begin
                keys     = {kind_key(KZ), kind_key(KT), kind_key(KT)};
                key_load = 1'b1;
            end else begin
                key_load = 1'b0;
            end
            chk($sformatf("busy_%0d", n), {47'd0, busy}, {47'd0, (n < 48)});
            chk($sformatf("done_%0d", n), {47'd0, sched_done}, {47'd0, (n == 48)});
            if (n == 10) begin
                rd_idx     = 6'd0;
                is_encrypt = 1'b1;
                #1;
                chk("gen_hidden", subkey, 48'd0);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        key_load   = 1'b1;
        keys       = {kind_key(KT), kind_key(KT), kind_key(KT)};
        is_encrypt = 1'b1;
        rd_idx     = 6'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {47'd0, busy}, 48'd0);
        chk("reset_done", {47'd0, sched_done}, 48'd0);
        chk("reset_subkey", subkey, 48'd0);
        rst      = 1'b0;
        key_load = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wins_busy", {47'd0, busy}, 48'd0);

        // Identical keys: timing and the directed read values.
        load(KT, KT, KT);
        cur_kind = '{KT, KT, KT};
        run_gen(-1, -1);
        read_chk("e0",  0,  1'b1, 48'h1B02EFFC7072);
        read_chk("e15", 15, 1'b1, 48'hCB3D8B0E17F5);
        read_chk("e16", 16, 1'b1, 48'hCB3D8B0E17F5);
        read_chk("e31", 31, 1'b1, 48'h1B02EFFC7072);
        read_chk("d0",  0,  1'b0, 48'hCB3D8B0E17F5);
        read_chk("d16", 16, 1'b0, 48'h1B02EFFC7072);
        read_chk("d47", 47, 1'b0, 48'h1B02EFFC7072);
        read_chk("d48", 48, 1'b0, 48'h0);
        read_chk("e63", 63, 1'b1, 48'h0);
        sweep("same");

        // Distinct keys, with a stray key_load during GEN.
        load(KT, KZ, KO);
        cur_kind = '{KT, KZ, KO};
        run_gen(20, -1);
        read_chk("x_e0",  0,  1'b1, 48'h1B02EFFC7072);
        read_chk("x_e16", 16, 1'b1, 48'h0);
        read_chk("x_e31", 31, 1'b1, 48'h0);
        read_chk("x_e32", 32, 1'b1, 48'hFFFFFFFFFFFF);
        sweep("dist");

        // Reload from DONE with new keys.
        load(KZ, KO, KT);
        cur_kind = '{KZ, KO, KT};
        run_gen(-1, -1);
        sweep("reload");

        // Reset part-way through GEN, then a full fresh schedule.
        load(KT, KT, KO);
        run_gen(-1, 30);
        @(negedge clk);
        rst = 1'b0;
        read_chk("post_rst_read", 0, 1'b1, 48'h0);
        chk("post_rst_busy", {47'd0, busy}, 48'd0);
        load(KO, KT, KZ);
        cur_kind = '{KO, KT, KZ};
        run_gen(-1, -1);
        sweep("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
